// File: rtl/dino_pkg.sv
// Shared constants and state encoding for the dino game difficulty path.
// Movers import the same defaults so their step rate agrees with the ramp.
package dino_pkg;

   localparam int BCD_W         = 4;
   localparam int DEF_ACC_W     = 8;
   localparam int DEF_INC_BASE  = 128;
   localparam int DEF_INC_STEP  = 16;
   localparam int DEF_MAX_LEVEL = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

endpackage

// File: rtl/obstacle_speed_ramp.sv
// Difficulty ramp: converts the 60 Hz game tick into a move strobe whose rate
// rises one level per change of the score's hundreds digit.
module obstacle_speed_ramp
   import dino_pkg::*;
#(
   parameter int ACC_W     = DEF_ACC_W,
   parameter int INC_BASE  = DEF_INC_BASE,
   parameter int INC_STEP  = DEF_INC_STEP,
   parameter int MAX_LEVEL = DEF_MAX_LEVEL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_tick,
   input  logic        game_start,
   input  logic        game_frozen,
   input  logic [15:0] score,
   output logic        move_tick,
   output logic [2:0]  level,
   output logic        running
);

   localparam logic [2:0] MAX_L = 3'(MAX_LEVEL);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [2:0]         level_q, level_d;
   logic [BCD_W-1:0]   prev_hund_q, prev_hund_d;
   logic               move_tick_q, move_tick_d;
   logic               running_q, running_d;

   logic [BCD_W-1:0]   hund;
   logic [ACC_W:0]     inc;
   logic [ACC_W:0]     sum;
   logic               stepping;

   assign hund = score[2*BCD_W +: BCD_W];

   // inc stays below 2**ACC_W, so one extra bit holds the sum and its carry
   assign inc = (ACC_W+1)'(INC_BASE) + (ACC_W+1)'(level_q) * (ACC_W+1)'(INC_STEP);
   assign sum = {1'b0, acc_q} + inc;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic; start outranks frozen
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (game_start) state_d = ST_RUN;
         ST_RUN:    if (!game_start && game_frozen) state_d = ST_FROZEN;
         ST_FROZEN: if (game_start) state_d = ST_RUN;
         default:   state_d = ST_IDLE;
      endcase
   end

   // stepping only while staying in RUN without a restart
   assign stepping = (state_q == ST_RUN) && !game_start && !game_frozen;

   // output / datapath logic
   always_comb begin
      acc_d       = acc_q;
      level_d     = level_q;
      prev_hund_d = prev_hund_q;
      move_tick_d = 1'b0;
      running_d   = (state_d == ST_RUN);
      if (game_start) begin
         acc_d       = '0;
         level_d     = '0;
         prev_hund_d = hund;
      end else if (stepping) begin
         if (game_tick) begin
            acc_d       = sum[ACC_W-1:0];
            move_tick_d = sum[ACC_W];
         end
         if (hund != prev_hund_q) begin
            prev_hund_d = hund;
            if (level_q < MAX_L) level_d = level_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         level_q     <= '0;
         prev_hund_q <= '0;
         move_tick_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         level_q     <= level_d;
         prev_hund_q <= prev_hund_d;
         move_tick_q <= move_tick_d;
         running_q   <= running_d;
      end
   end

   assign move_tick = move_tick_q;
   assign level     = level_q;
   assign running   = running_q;

endmodule

// File: tb/tb_obstacle_speed_ramp.sv
// Directed plus randomized bench for obstacle_speed_ramp against a
// cycle-level arithmetic model of the difficulty ramp.
module tb_obstacle_speed_ramp;

   localparam int ACC_W = 8, INC_BASE = 128, INC_STEP = 16, MAX_LEVEL = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        game_tick = 1'b0, game_start = 1'b0, game_frozen = 1'b0;
   logic [15:0] score = 16'h0000;
   logic        move_tick;
   logic [2:0]  level;
   logic        running;

   int n_cmp = 0, n_fail = 0, mt_cnt = 0;

   // reference model: mode 0 idle, 1 run, 2 frozen
   int m_mode = 0, m_acc = 0, m_level = 0, m_prev = 0;
   logic e_mt = 1'b0, e_run = 1'b0;

   obstacle_speed_ramp #(.ACC_W(ACC_W), .INC_BASE(INC_BASE), .INC_STEP(INC_STEP),
                         .MAX_LEVEL(MAX_LEVEL)) dut (
      .clk(clk), .rst(rst), .game_tick(game_tick), .game_start(game_start),
      .game_frozen(game_frozen), .score(score), .move_tick(move_tick),
      .level(level), .running(running));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_acc = 0; m_level = 0; m_prev = 0; e_mt = 0; e_run = 0;
   endtask

   task automatic model_step(input bit s, input bit f, input bit t, input int hund);
      e_mt = 0;
      if (s) begin
         m_mode = 1; m_acc = 0; m_level = 0; m_prev = hund;
      end else if (m_mode == 1) begin
         if (f) m_mode = 2;
         else begin
            if (t) begin
               m_acc += INC_BASE + m_level * INC_STEP;
               if (m_acc >= (1 << ACC_W)) begin e_mt = 1; m_acc -= (1 << ACC_W); end
            end
            if (hund != m_prev) begin
               m_prev = hund;
               if (m_level < MAX_LEVEL) m_level++;
            end
         end
      end
      e_run = (m_mode == 1);
   endtask

   // called at posedge+1: apply inputs for one cycle, then check after next edge
   task automatic cyc(input bit s, input bit f, input bit t, input string tag);
      game_start = s; game_frozen = f; game_tick = t;
      model_step(s, f, t, int'(score[11:8]));
      @(posedge clk); #1;
      game_start = 0; game_frozen = 0; game_tick = 0;
      if (move_tick) mt_cnt++;
      chk({tag, ".move_tick"}, int'(move_tick), int'(e_mt));
      chk({tag, ".level"},     int'(level),     m_level);
      chk({tag, ".running"},   int'(running),   int'(e_run));
   endtask

   initial begin
      int   start_cnt;
      logic [3:0] d;
      repeat (2) @(posedge clk); #1;
      chk("rst.move_tick", int'(move_tick), 0);
      chk("rst.level",     int'(level),     0);
      chk("rst.running",   int'(running),   0);
      rst = 0; model_reset();

      for (int i = 0; i < 10; i++) cyc(0, 0, 1, "idle");

      // level-0 rate: 20 ticks spaced 4 cycles -> 10 moves
      cyc(1, 0, 0, "start0");
      start_cnt = mt_cnt;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 1, "lvl0");
         repeat (3) cyc(0, 0, 0, "lvl0gap");
      end
      chk("lvl0.count", mt_cnt - start_cnt, 10);

      // ramp: hundreds digit 1..9, level saturates at 7; tick coincident with change
      for (int h = 1; h <= 9; h++) begin
         d = 4'(h);
         score = {4'h0, d, 8'h00};
         cyc(0, 0, 1, "ramp");
         cyc(0, 0, 1, "ramp2");
      end
      chk("ramp.sat", int'(level), 7);
      start_cnt = mt_cnt;
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, "lvl7");
      chk("lvl7.count", mt_cnt - start_cnt, 15);

      // restart to level 3 then freeze and change score
      score = 16'h0000;
      cyc(1, 0, 0, "restart");
      for (int h = 1; h <= 3; h++) begin
         d = 4'(h);
         score = {4'h0, d, 8'h00};
         cyc(0, 0, 1, "to3");
      end
      cyc(0, 1, 0, "freeze");
      for (int i = 0; i < 6; i++) begin
         score = score + 16'h0100;
         cyc(0, 0, 1, "frozen");
      end
      chk("frozen.level", int'(level), 3);

      // start with coincident tick/frozen from FROZEN
      cyc(1, 1, 1, "start_frz");
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, "resume");

      // 9999 -> 0000 wrap counts as a hundreds change
      score = 16'h9999;
      cyc(1, 0, 0, "wrapstart");
      score = 16'h0000;
      cyc(0, 0, 0, "wrap");
      chk("wrap.level", int'(level), 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit s, f, t;
         t = ($urandom_range(0, 2) != 0);
         s = ($urandom_range(0, 39) == 0);
         f = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 7) == 0) begin
            d = 4'($urandom_range(0, 9));
            score = {4'($urandom_range(0, 9)), d, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         cyc(s, f, t, "rand");
      end

      // async reset while move_tick is high
      cyc(1, 0, 0, "pre_ar");
      begin
         int guard = 0;
         while (!move_tick && guard < 10) begin cyc(0, 0, 1, "seek"); guard++; end
      end
      chk("ar.pre", int'(move_tick), 1);
      #2 rst = 1;
      #1;
      chk("ar.move_tick", int'(move_tick), 0);
      chk("ar.level",     int'(level),     0);
      chk("ar.running",   int'(running),   0);
      @(posedge clk); #1 rst = 0; model_reset();
      cyc(0, 0, 1, "post_ar");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/obstacle_speed_ramp.md
# obstacle_speed_ramp

Difficulty controller that sits directly upstream of the obstacle and background-object movers. It consumes the 60 Hz game tick, the game start/frozen status from the player controller, and the BCD score from the score module. From these it produces a `move_tick` strobe whose rate rises by one level each time the score's hundreds digit changes. The movers advance one step per `move_tick` instead of per raw 60 Hz tick.

## Interface
- `ACC_W`, default 8: phase accumulator width.
- `INC_BASE`, default 128: accumulator increment at level 0, i.e. one move per 2 game ticks.
- `INC_STEP`, default 16: extra increment per level.
- `MAX_LEVEL`, default 7: level saturation value; requires `INC_BASE + MAX_LEVEL*INC_STEP < 2**ACC_W`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `game_tick` in 1: one-cycle 60 Hz pulse, synchronous to `clk`.
- `game_start` in 1: one-cycle pulse that starts or restarts a run.
- `game_frozen` in 1: level signal, high while the game is over or paused.
- `score` in 16: 4-digit BCD score; `score[11:8]` is the hundreds digit.
- `move_tick` out 1: one-cycle movement strobe.
- `level` out 3: current difficulty level, 0..`MAX_LEVEL`.
- `running` out 1: high in RUN.

## Operation
- **States** (2-bit encoding):
  - IDLE: entered on reset.
  - RUN.
  - FROZEN.
- **Transitions:**
  - IDLE → RUN on `game_start`.
  - RUN → FROZEN when `game_frozen`=1 and `game_start`=0.
  - FROZEN → RUN on `game_start`.
  - RUN + `game_start` → RUN with a restart.
  - `game_start` has priority over `game_frozen` in the same cycle.
- **Entry into RUN on `game_start`:**
  - `acc`←0, `level`←0.
  - `prev_hund`←`score[11:8]` as sampled that cycle.
  - No `move_tick` is generated from a `game_tick` coincident with `game_start`.
- **Per-`game_tick` stepping, RUN only:**
  - `inc` = `INC_BASE + level*INC_STEP`, computed in `ACC_W+1` bits.
  - `{carry, acc}` ← `acc + inc`.
  - `move_tick` is registered from `carry`.
- **Level update, RUN only, evaluated every cycle:**
  - If `score[11:8]` ≠ `prev_hund`, then `prev_hund`←`score[11:8]` and `level`←min(`level`+1, `MAX_LEVEL`).
  - Score wrap 9999→0000 changes the hundreds digit 9→0 and counts as a change.
- **Level change coincident with `game_tick`:** the step uses the old level's `inc`; the new level applies from the next tick.
- **In IDLE and FROZEN:**
  - `acc`, `level` and `prev_hund` hold.
  - `move_tick`=0.
  - `score` changes are ignored.
- `level` remains readable in FROZEN, so the final difficulty can be displayed.
- Without `game_frozen`, the block never leaves RUN; `game_start` restarts it.

## Timing
- **Reset values:** state=IDLE, `acc`=0, `level`=0, `prev_hund`=0, `move_tick`=0, `running`=0.
- **Reset assertion:** mid-operation it takes effect immediately, clearing all outputs asynchronously. Release is synchronous to the next `clk` edge.
- **`move_tick` latency:** asserts exactly 1 `clk` cycle after the qualifying `game_tick`, for exactly one cycle.
- **`running`:** registered state decode. Rises 1 cycle after `game_start`; falls 1 cycle after `game_frozen` is seen in RUN.
- **`level`:** updates 1 cycle after the score digit change is sampled.
- **Back-to-back `game_tick`s:** must be accepted on consecutive cycles; each produces an independent `move_tick`. This holds for all inputs; no stall or handshake exists.
- **`game_start` in same cycle as `game_tick` from FROZEN:** RUN is entered with `acc`=0 and no `move_tick` results.

## Structure
- Shared package `dino_pkg`:
  - state typedef (IDLE/RUN/FROZEN) and its 2-bit encoding;
  - BCD digit width constant (4);
  - default `ACC_W`/`INC_BASE`/`INC_STEP`/`MAX_LEVEL` constants, so the obstacle movers use the same values.
- No sub-module is needed; the increment is a single multiply-add on a 3-bit level. Keep the block as one module.
- Integration:
  - `move_tick` replaces the raw 60 Hz tick as the advance enable of the obstacle and background-object movers.
  - `level` is available to rendering.

## Test plan
- **Reset/idle:** assert `rst`, then release and send 10 `game_tick`s with no `game_start` → `move_tick` stays 0, `level`=0, `running`=0.
- **Level-0 rate:** send `game_start`, then 20 `game_tick`s spaced 4 cycles apart with score constant → exactly 10 `move_tick`s, on the 2nd, 4th, … ticks. Each `move_tick` arrives 1 cycle after its `game_tick`.
- **Ramp and saturation:**
  - Step `score` 0x0000→0x0100→…→0x0900 during RUN → `level` goes 1..7 and then holds at 7.
  - At level 7 (`inc`=240), 16 ticks → 15 `move_tick`s.
- **Simultaneous events:**
  - Level change and `game_tick` in the same cycle → that step uses the old `inc`.
  - `game_start` and `game_frozen` in the same cycle → state is RUN and `acc`=0.
- **Freeze/restart:**
  - Raise `game_frozen` mid-run → `running` falls after 1 cycle and there are no further `move_tick`s. `level` holds at its value (e.g. 3) while `score` changes.
  - `game_start` → `level`=0 and `move_tick`s resume at the level-0 rate.
- **Wrap and async reset:**
  - Score 0x9999→0x0000 in RUN → `level` increments.
  - Assert `rst` mid-cycle while `move_tick`=1 → `move_tick` drops before the next clock edge.
